// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit CPU pipeline.
// Holds the instruction field positions, opcode constants, decode helpers
// and the operand-fetch -> ALU payload struct. The ALU and later stages
// use this package as well.
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int RA_W  = 3;

  // Instruction field positions
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int TYPE_B  = 11;
  localparam int RD_HI   = 10;
  localparam int RD_LO   = 8;
  localparam int RS_HI   = 7;
  localparam int RS_LO   = 5;
  localparam int RM_HI   = 4;
  localparam int RM_LO   = 2;
  localparam int IMM_HI  = 4;
  localparam int IMM_LO  = 0;

  // Opcodes; R/I variants share an opcode and differ only in the type bit
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_MAS = 4'b0110;
  localparam logic [3:0] OP_LSL = 4'b1100;
  localparam logic [3:0] OP_LSR = 4'b1101;

  localparam logic TYPE_R = 1'b0;
  localparam logic TYPE_I = 1'b1;

  // Payload handed to the ALU
  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] rddata;
    logic [WIDTH-1:0] rsdata;
    logic [WIDTH-1:0] rmdata;
    logic [WIDTH-1:0] n;
  } fetch_t;

  function automatic logic [3:0] opcode_of(input logic [WIDTH-1:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic is_itype(input logic [WIDTH-1:0] instr);
    return instr[TYPE_B] == TYPE_I;
  endfunction

  function automatic logic [RA_W-1:0] rd_of(input logic [WIDTH-1:0] instr);
    return instr[RD_HI:RD_LO];
  endfunction

  function automatic logic [RA_W-1:0] rs_of(input logic [WIDTH-1:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [RA_W-1:0] rm_of(input logic [WIDTH-1:0] instr);
    return instr[RM_HI:RM_LO];
  endfunction

  // Zero-extended 5-bit immediate for I-type, zero for R-type
  function automatic logic [WIDTH-1:0] imm_of(input logic [WIDTH-1:0] instr);
    logic [WIDTH-1:0] n;
    n = '0;
    if (is_itype(instr)) n[IMM_HI:IMM_LO] = instr[IMM_HI:IMM_LO];
    return n;
  endfunction

  // Writers are the 01xx and 11xx opcode groups
  function automatic logic is_writer(input logic [WIDTH-1:0] instr);
    return instr[OP_LO+2];
  endfunction

  // MAS accumulates into Rd, so Rd is also a source
  function automatic logic reads_rd(input logic [WIDTH-1:0] instr);
    return opcode_of(instr) == OP_MAS;
  endfunction

  // Rm is a source only for R-type writers
  function automatic logic uses_rm(input logic [WIDTH-1:0] instr);
    return is_writer(instr) && !is_itype(instr);
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// regfile_8x16: register file for the operand-fetch stage.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset (clears all regs)
//   wen/waddr/wdata  - synchronous write port
//   raddr[NRP]       - read indices, packed per read port
//   rdata[NRP]       - combinational read data; a same-cycle write to the
//                      read index is forwarded (write-through bypass)
module regfile_8x16
  import cpu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 16,
  parameter int NRP   = 3,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wen,
  input  logic [AW-1:0]             waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [NRP-1:0][AW-1:0]    raddr,
  output logic [NRP-1:0][WIDTH-1:0] rdata
);

  logic [NREGS-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    mem        <= '0;
    else if (wen) mem[waddr] <= wdata;
  end

  for (genvar rp = 0; rp < NRP; rp++) begin : g_rd
    assign rdata[rp] = (wen && waddr == raddr[rp]) ? wdata : mem[raddr[rp]];
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage in front of the combinational ALU.
// Decodes Rd/Rs/Rm/N, reads operands from the register file, tracks
// outstanding writes in a per-register busy scoreboard and holds one
// instruction in an output buffer.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr     - instruction input handshake
//   wb_en/wb_addr/wb_data          - writeback from the ALU result path
//   out_valid/out_ready            - output buffer handshake
//   out_instr, out_rddata, out_rsdata, out_rmdata, out_n - buffered payload
//   busy                           - scoreboard bits (debug/verification)
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_instr,
  input  logic             wb_en,
  input  logic [2:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_rddata,
  output logic [WIDTH-1:0] out_rsdata,
  output logic [WIDTH-1:0] out_rmdata,
  output logic [WIDTH-1:0] out_n,
  output logic [NREGS-1:0] busy
);

  localparam int AW = 3;
  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  // Decode
  logic [AW-1:0] rd, rs, rm;
  logic          writer;
  assign rd     = rd_of(in_instr);
  assign rs     = rs_of(in_instr);
  assign rm     = rm_of(in_instr);
  assign writer = is_writer(in_instr);

  // Operand read: port 0 = Rd, 1 = Rs, 2 = Rm
  logic [2:0][AW-1:0]    raddr;
  logic [2:0][WIDTH-1:0] rdata;
  assign raddr = {rm, rs, rd};

  regfile_8x16 #(.NREGS(NREGS), .WIDTH(WIDTH), .NRP(3), .AW(AW)) u_rf (
    .clk   (clk),
    .reset (reset),
    .wen   (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Scoreboard. A writeback landing this cycle un-busies its register for
  // the hazard check because the read port forwards wb_data.
  logic [NREGS-1:0] busy_q, wb_clr, iss_set, eff_busy;
  logic             hazard, accept;

  assign wb_clr   = wb_en ? (ONE_HOT0 << wb_addr) : '0;
  assign eff_busy = busy_q & ~wb_clr;

  // The destination is checked for every writer, which also covers the
  // MAS read of Rd; reads_rd is kept explicit so the source set is visible.
  assign hazard = (writer && (eff_busy[rs] || eff_busy[rd] ||
                              (uses_rm(in_instr) && eff_busy[rm]))) ||
                  (reads_rd(in_instr) && eff_busy[rd]);

  // Combinational on in_instr by design: the hazard depends on the word
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign iss_set  = (accept && writer) ? (ONE_HOT0 << rd) : '0;

  // Set after clear so an issue wins over a same-cycle writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= (busy_q & ~wb_clr) | iss_set;
  end

  // Output buffer; vld_pipe[0] is the accept strobe, vld_pipe[1] the held
  // buffer valid, which drops only when consumed without a replacement.
  logic [1:0] vld_pipe;
  fetch_t     ob_q;
  assign vld_pipe[0] = accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      ob_q        <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0] || (vld_pipe[1] && !out_ready);
      if (accept) begin
        ob_q.instr  <= in_instr;
        ob_q.rddata <= rdata[0];
        ob_q.rsdata <= rdata[1];
        ob_q.rmdata <= rdata[2];
        ob_q.n      <= imm_of(in_instr);
      end
    end
  end

  assign out_valid  = vld_pipe[1];
  assign out_instr  = ob_q.instr;
  assign out_rddata = ob_q.rddata;
  assign out_rsdata = ob_q.rsdata;
  assign out_rmdata = ob_q.rmdata;
  assign out_n      = ob_q.n;
  assign busy       = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_instr;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [15:0] out_instr, out_rddata, out_rsdata, out_rmdata, out_n;
  logic [7:0]  busy;

  always #5 clk = ~clk;

  operand_fetch #(.NREGS(8), .WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_rddata(out_rddata), .out_rsdata(out_rsdata),
    .out_rmdata(out_rmdata), .out_n(out_n), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural registers, busy set, one-entry buffer
  logic [15:0] m_reg [8];
  bit          m_busy [8];
  bit          m_ov;
  logic [15:0] m_instr, m_rd, m_rs, m_rm, m_n;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fld(input logic [15:0] i, input int lsb, input int w);
    return int'(i >> lsb) % (1 << w);
  endfunction

  function automatic bit m_writer(input logic [15:0] i);
    int grp = fld(i, 14, 2);
    return grp == 1 || grp == 3;
  endfunction

  // Register value as seen this cycle, including a forwarded writeback
  function automatic logic [15:0] m_read(input int idx);
    if (wb_en && int'(wb_addr) == idx) return wb_data;
    return m_reg[idx];
  endfunction

  function automatic bit m_pending(input int idx);
    return m_busy[idx] && !(wb_en && int'(wb_addr) == idx);
  endfunction

  function automatic bit m_ready();
    bit stall = 0;
    if (m_writer(in_instr)) begin
      if (m_pending(fld(in_instr, 5, 3))) stall = 1;
      if (m_pending(fld(in_instr, 8, 3))) stall = 1;
      if (fld(in_instr, 11, 1) == 0 && m_pending(fld(in_instr, 2, 3))) stall = 1;
    end
    return (!m_ov || out_ready) && !stall;
  endfunction

  function automatic logic [7:0] m_busy_vec();
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) if (m_busy[k]) v = v | (8'd1 << k);
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 8; k++) begin m_reg[k] = '0; m_busy[k] = 0; end
    m_ov = 0; m_instr = '0; m_rd = '0; m_rs = '0; m_rm = '0; m_n = '0;
  endtask

  // One clock cycle: drive, check in_ready, advance model, check outputs
  task automatic step(input bit iv, input logic [15:0] ins, input bit we,
                      input int wa, input logic [15:0] wd, input bit ordy,
                      output bit rdy_seen);
    bit exp_rdy, acc;
    in_valid = iv; in_instr = ins; wb_en = we; wb_addr = 3'(wa);
    wb_data = wd; out_ready = ordy;
    #1;
    rdy_seen = in_ready;
    exp_rdy  = m_ready();
    chk("in_ready", 16'(in_ready), 16'(exp_rdy));
    acc = iv && exp_rdy;
    if (acc) begin
      m_instr = ins;
      m_rd = m_read(fld(ins, 8, 3));
      m_rs = m_read(fld(ins, 5, 3));
      m_rm = m_read(fld(ins, 2, 3));
      m_n  = fld(ins, 11, 1) == 1 ? 16'(fld(ins, 0, 5)) : 16'd0;
      m_ov = 1;
    end else if (ordy) m_ov = 0;
    if (we) begin m_busy[wa] = 0; m_reg[wa] = wd; end
    if (acc && m_writer(ins)) m_busy[fld(ins, 8, 3)] = 1;
    @(posedge clk); #1;
    chk("out_valid", 16'(out_valid), 16'(m_ov));
    chk("out_instr", out_instr, m_instr);
    chk("out_rddata", out_rddata, m_rd);
    chk("out_rsdata", out_rsdata, m_rs);
    chk("out_rmdata", out_rmdata, m_rm);
    chk("out_n", out_n, m_n);
    chk("busy", 16'(busy), 16'(m_busy_vec()));
  endtask

  typedef struct {
    bit iv; logic [15:0] ins; bit we; int wa; logic [15:0] wd; bit ordy;
    bit e_rdy; bit e_ov; logic [15:0] e_instr, e_rd, e_rs, e_rm, e_n;
    logic [7:0] e_busy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit r;
    logic [15:0] hold_i, hold_s, hold_m;

    tbl[0]  = '{0, 16'h0000, 1, 1, 16'd5,  1, 1, 0, 16'h0000, 16'd0, 16'd0,  16'd0,  16'd0,  8'h00};
    tbl[1]  = '{0, 16'h0000, 1, 2, 16'd7,  1, 1, 0, 16'h0000, 16'd0, 16'd0,  16'd0,  16'd0,  8'h00};
    tbl[2]  = '{1, 16'h4128, 0, 0, 16'd0,  1, 1, 1, 16'h4128, 16'd5, 16'd5,  16'd7,  16'd0,  8'h02};
    tbl[3]  = '{1, 16'h4320, 0, 0, 16'd0,  1, 0, 0, 16'h4128, 16'd5, 16'd5,  16'd7,  16'd0,  8'h02};
    tbl[4]  = '{1, 16'h4320, 1, 1, 16'd12, 1, 1, 1, 16'h4320, 16'd0, 16'd12, 16'd0,  16'd0,  8'h08};
    tbl[5]  = '{1, 16'h4C13, 0, 0, 16'd0,  1, 1, 1, 16'h4C13, 16'd0, 16'd0,  16'd0,  16'd19, 8'h18};
    tbl[6]  = '{1, 16'h0020, 0, 0, 16'd0,  1, 1, 1, 16'h0020, 16'd0, 16'd12, 16'd0,  16'd0,  8'h18};
    tbl[7]  = '{1, 16'h0000, 0, 0, 16'd0,  0, 0, 1, 16'h0020, 16'd0, 16'd12, 16'd0,  16'd0,  8'h18};
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = '{1, 16'h4D25, 0, 0, 16'd0,  1, 1, 1, 16'h4D25, 16'd0, 16'd12, 16'd12, 16'd5,  8'h38};
    tbl[11] = '{0, 16'h0000, 0, 0, 16'd0,  1, 1, 0, 16'h4D25, 16'd0, 16'd12, 16'd12, 16'd5,  8'h38};

    // Reset state
    reset = 1; in_valid = 0; in_instr = '0; wb_en = 0; wb_addr = '0;
    wb_data = '0; out_ready = 0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst out_valid", 16'(out_valid), 16'd0);
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst out_instr", out_instr, 16'd0);
    chk("rst out_rsdata", out_rsdata, 16'd0);
    chk("rst out_n", out_n, 16'd0);
    reset = 0;

    // Directed table
    for (int v = 0; v < 12; v++) begin
      step(tbl[v].iv, tbl[v].ins, tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].ordy, r);
      chk($sformatf("tbl%0d in_ready", v), 16'(r), 16'(tbl[v].e_rdy));
      chk($sformatf("tbl%0d out_valid", v), 16'(out_valid), 16'(tbl[v].e_ov));
      chk($sformatf("tbl%0d out_instr", v), out_instr, tbl[v].e_instr);
      chk($sformatf("tbl%0d out_rddata", v), out_rddata, tbl[v].e_rd);
      chk($sformatf("tbl%0d out_rsdata", v), out_rsdata, tbl[v].e_rs);
      chk($sformatf("tbl%0d out_rmdata", v), out_rmdata, tbl[v].e_rm);
      chk($sformatf("tbl%0d out_n", v), out_n, tbl[v].e_n);
      chk($sformatf("tbl%0d busy", v), 16'(busy), 16'(tbl[v].e_busy));
    end

    // Output held stable while not consumed
    step(1, 16'h0000, 0, 0, 16'd0, 1, r);
    hold_i = out_instr; hold_s = out_rsdata; hold_m = out_rmdata;
    for (int c = 0; c < 3; c++) begin
      step(1, 16'h00E0, 0, 0, 16'd0, 0, r);
      chk("hold in_ready", 16'(r), 16'd0);
      chk("hold instr", out_instr, hold_i);
      chk("hold rsdata", out_rsdata, hold_s);
      chk("hold rmdata", out_rmdata, hold_m);
    end
    step(1, 16'h00E0, 0, 0, 16'd0, 1, r);
    chk("replace valid", 16'(out_valid), 16'd1);
    chk("replace instr", out_instr, 16'h00E0);

    // MAS with Rd (R3) busy stalls until R3 writes back; the following
    // non-writer waits behind it and issues next
    for (int c = 0; c < 2; c++) begin
      step(1, 16'h6B01, 0, 0, 16'd0, 1, r);
      chk("mas stall", 16'(r), 16'd0);
    end
    step(1, 16'h6B01, 1, 3, 16'h0033, 1, r);
    chk("mas accept", 16'(r), 16'd1);
    chk("mas instr", out_instr, 16'h6B01);
    chk("mas rddata", out_rddata, 16'h0033);
    chk("mas busy set wins", 16'(busy), 16'h0038);
    step(1, 16'h0000, 0, 0, 16'd0, 1, r);
    chk("after mas instr", out_instr, 16'h0000);

    // Fill the scoreboard, then reset with a concurrent writeback
    for (int k = 0; k < 8; k++) step(0, 16'h0000, 1, k, 16'(k * 3 + 1), 1, r);
    for (int k = 0; k < 8; k++)
      step(1, 16'h4800 | 16'(k << 8) | 16'(k << 5), 0, 0, 16'd0, 1, r);
    chk("busy full", 16'(busy), 16'h00FF);
    chk("full valid", 16'(out_valid), 16'd1);
    in_valid = 0; wb_en = 1; wb_addr = 3'd2; wb_data = 16'h0099; reset = 1;
    #1;
    chk("mid rst out_valid", 16'(out_valid), 16'd0);
    chk("mid rst busy", 16'(busy), 16'd0);
    chk("mid rst out_rsdata", out_rsdata, 16'd0);
    chk("mid rst out_instr", out_instr, 16'd0);
    @(posedge clk); #1;
    reset = 0; wb_en = 0;
    m_reset();
    step(1, 16'h0028, 0, 0, 16'd0, 1, r);
    chk("rst R1", out_rsdata, 16'd0);
    chk("rst R2 discarded wb", out_rmdata, 16'd0);
    step(1, 16'h07FC, 0, 0, 16'd0, 1, r);
    chk("rst R7", out_rsdata, 16'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) == 0,
           int'($urandom % 8), 16'($urandom), ($urandom % 4) != 0, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
